// File: rtl/mem_responder_pkg.sv
// Shared types and widths for the mem_responder memory slave.
package mem_responder_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

endpackage

// File: rtl/mem_responder_array.sv
// Word storage for mem_responder: synchronous write, registered read.
// The read register clears to zero so store/error responses carry no data.
module mem_responder_array
  import mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 64
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           i_we,
  input  logic                           i_re,
  input  logic                           i_clr,
  input  logic [$clog2(DEPTH_WORDS)-1:0] i_idx,
  input  logic [WORD_W-1:0]              i_wdata,
  output logic [WORD_W-1:0]              o_rdata
);

  logic [WORD_W-1:0] r_mem [DEPTH_WORDS];
  logic [WORD_W-1:0] r_rdata;

  // Contents are deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_idx] <= i_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_idx];
    end else if (i_clr) begin
      r_rdata <= '0;
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_responder.sv
// Wait-stated word memory responder: IDLE/WAIT/RESP handshake FSM in front of
// mem_responder_array. Define MEM_RESPONDER_ERRCHK_EN to reject misaligned or
// out-of-range addresses; otherwise addresses wrap modulo DEPTH_WORDS.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [WORD_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int unsigned      AW      = $clog2(DEPTH_WORDS);
  localparam logic [CNT_W-1:0] WAIT_LD = CNT_W'(WAIT_CYCLES);

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_write;
  logic [AW-1:0]       r_idx;
  logic [WORD_W-1:0]   r_wdata;
  logic                r_req_err;
  logic                r_rsp_valid;
  logic                r_rsp_err;

  logic                w_accept;
  logic                w_req_err;
  logic [AW-1:0]       w_req_idx;
  logic                w_enter_resp;
  logic                w_acc_write;
  logic                w_acc_err;
  logic [AW-1:0]       w_acc_idx;
  logic [WORD_W-1:0]   w_acc_wdata;

  assign req_ready = (r_state == IDLE);
  assign w_accept  = req_valid && req_ready;
  assign w_req_idx = req_addr[AW+1:2];

`ifdef MEM_RESPONDER_ERRCHK_EN
  assign w_req_err = (req_addr[1:0] != 2'b00) ||
                     ({2'b00, req_addr[31:2]} >= 32'(DEPTH_WORDS));
`else
  logic w_unused;
  assign w_req_err = 1'b0;
  assign w_unused  = ^{req_addr[WORD_W-1:AW+2], req_addr[1:0]};
`endif

  // With zero wait states the array is accessed on the accept edge itself,
  // so the access takes the live request instead of the latched copy.
  assign w_acc_write  = req_ready ? req_write : r_write;
  assign w_acc_err    = req_ready ? w_req_err : r_req_err;
  assign w_acc_idx    = req_ready ? w_req_idx : r_idx;
  assign w_acc_wdata  = req_ready ? req_wdata : r_wdata;
  assign w_enter_resp = reset &&
                        ((w_accept && (WAIT_CYCLES == 0)) ||
                         ((r_state == WAIT) && (r_cnt == CNT_W'(1))));

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_write   <= req_write;
            r_idx     <= w_req_idx;
            r_wdata   <= req_wdata;
            r_req_err <= w_req_err;
            r_cnt     <= WAIT_LD;
            if (WAIT_CYCLES == 0) begin
              r_state     <= RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= w_req_err;
            end else begin
              r_state <= WAIT;
            end
          end
        end
        WAIT: begin
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            r_state     <= RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= r_req_err;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            r_state     <= IDLE;
            r_rsp_valid <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_err   = r_rsp_err;

  mem_responder_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clk    (clk),
    .reset  (reset),
    .i_we   (w_enter_resp && w_acc_write && !w_acc_err),
    .i_re   (w_enter_resp && !w_acc_write && !w_acc_err),
    .i_clr  (w_enter_resp && (w_acc_write || w_acc_err)),
    .i_idx  (w_acc_idx),
    .i_wdata(w_acc_wdata),
    .o_rdata(rsp_rdata)
  );

endmodule
